// File: rtl/tree_walker_if.sv
// tree_walker_if: feature input, tree ROM read port and result handshake of tree_walker.
// `TREE_WALK_DEPTH_OUT_EN adds result_depth, the internal-node count of the finished walk.
interface tree_walker_if #(
    parameter int NODE_WIDTH   = 120,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_WIDTH   = 32,
    parameter int CLASS_WIDTH  = 8
);
    logic                               in_valid;
    logic                               in_ready;
    logic [NUM_FEATURES*FEAT_WIDTH-1:0] features;
    logic [ADDR_WIDTH-1:0]              rom_addr;
    logic [NODE_WIDTH-1:0]              rom_data;
    logic                               result_valid;
    logic                               result_ready;
    logic [CLASS_WIDTH-1:0]             result_class;
    logic                               result_err;
`ifdef TREE_WALK_DEPTH_OUT_EN
    logic [7:0]                         result_depth;
    modport master (
        input  in_valid, features, rom_data, result_ready,
        output in_ready, rom_addr, result_valid, result_class, result_err, result_depth
    );
    modport slave (
        output in_valid, features, rom_data, result_ready,
        input  in_ready, rom_addr, result_valid, result_class, result_err, result_depth
    );
`else
    modport master (
        input  in_valid, features, rom_data, result_ready,
        output in_ready, rom_addr, result_valid, result_class, result_err
    );
    modport slave (
        output in_valid, features, rom_data, result_ready,
        input  in_ready, rom_addr, result_valid, result_class, result_err
    );
`endif
endinterface

// File: rtl/tree_walker.sv
// tree_walker: walks one decision tree in a registered-output ROM per feature vector.
// `TREE_WALK_DEPTH_OUT_EN also reports the internal-node count of each walk.
module tree_walker #(
    parameter int NODE_WIDTH   = 120,
    parameter int ADDR_WIDTH   = 10,
    parameter int ROM_DEPTH    = 512,
    parameter int NUM_FEATURES = 16,
    parameter int FEAT_WIDTH   = 32,
    parameter int CLASS_WIDTH  = 8,
    parameter int MAX_DEPTH    = 32,
    parameter int ROOT_ADDR    = 0
) (
    input logic         clk,
    input logic         rst,
    tree_walker_if.master bus
);
    localparam int DW = $clog2(MAX_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, EVAL, DONE} state_t;

    state_t                        state, state_nx;
    logic signed [FEAT_WIDTH-1:0]  feats [NUM_FEATURES];
    logic [DW-1:0]                 depth;
    logic                          is_leaf, abort, accept;
    logic [3:0]                    fidx;
    logic signed [FEAT_WIDTH-1:0]  thr, fval;
    logic [11:0]                   next;
    logic                          unused_bits;

    assign unused_bits = ^{bus.rom_data[118:108], bus.rom_data[71:40], bus.rom_data[15:CLASS_WIDTH]};

    // Node decode and branch decision; only meaningful while in EVAL
    always_comb begin
        is_leaf = bus.rom_data[119];
        fidx    = bus.rom_data[107:104];
        thr     = bus.rom_data[72 +: FEAT_WIDTH];
        fval    = 32'(fidx) < NUM_FEATURES ? feats[fidx] : '0;
        next    = fval <= thr ? bus.rom_data[39:28] : bus.rom_data[27:16];
        abort   = 32'(fidx) >= NUM_FEATURES || depth == DW'(MAX_DEPTH) || 32'(next) >= ROM_DEPTH;
        accept  = bus.in_valid && state == IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = accept ? ISSUE : IDLE;
            ISSUE: state_nx = EVAL;
            EVAL:  state_nx = (is_leaf || abort) ? DONE : ISSUE;
            DONE:  state_nx = bus.result_ready ? IDLE : DONE;
        endcase
    end

    always_comb begin
        bus.in_ready     = state == IDLE;
        bus.result_valid = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rom_addr     <= ADDR_WIDTH'(ROOT_ADDR);
            depth            <= '0;
            bus.result_class <= '0;
            bus.result_err   <= 1'b0;
`ifdef TREE_WALK_DEPTH_OUT_EN
            bus.result_depth <= '0;
`endif
        end else if (accept) begin
            for (int i = 0; i < NUM_FEATURES; i++)
                feats[i] <= bus.features[i*FEAT_WIDTH +: FEAT_WIDTH];
            bus.rom_addr <= ADDR_WIDTH'(ROOT_ADDR);
            depth        <= '0;
        end else if (state == EVAL) begin
            if (is_leaf || abort) begin
                bus.result_class <= is_leaf ? bus.rom_data[CLASS_WIDTH-1:0] : '0;
                bus.result_err   <= !is_leaf;
`ifdef TREE_WALK_DEPTH_OUT_EN
                bus.result_depth <= 8'(depth);
`endif
            end else begin
                bus.rom_addr <= next[ADDR_WIDTH-1:0];
                depth        <= depth + DW'(1);
            end
        end
    end
endmodule
